// File: rtl/exception_pc_sequencer_pkg.sv
// Shared types and encodings for the exception/RTE PC sequencer.
// Holds the FSM state enum, the exception cause codes and the PC-source mux select values.
package exception_pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_VEC_WAIT = 3'd2,
        ST_LOAD_PC  = 3'd3,
        ST_RTE      = 3'd4
    } state_e;

    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV0   = 2'd2;

    localparam logic [1:0] PCS_ALURES = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_EPC    = 2'b11;

    localparam logic [31:0] VEC_BASE_DEFAULT = 32'd253;

endpackage

// File: rtl/exception_pc_sequencer.sv
// Owns PC-source select and PC write: passes the control unit through in IDLE, otherwise
// runs exception entry (EPC capture, vector fetch, PC load) or RTE (PC <= EPC).
module exception_pc_sequencer
    import exception_pc_sequencer_pkg::*;
#(
    parameter int          MEM_LATENCY = 2,
    parameter logic [31:0] VEC_BASE    = VEC_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ctrl_pc_source,
    input  logic        ctrl_pc_write,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic        rte_req,
    input  logic [31:0] pc_q,
    input  logic [7:0]  mem_rdata,
    output logic [1:0]  pc_source,
    output logic        pc_write,
    output logic        handler_sel,
    output logic [31:0] handler_addr,
    output logic        mem_addr_sel,
    output logic [31:0] exc_vec_addr,
    output logic [31:0] epc,
    output logic        busy,
    output state_e      dbg_state
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_e             state_q;
    logic [1:0]         cause_q;
    logic [31:0]        epc_q;
    logic [7:0]         hbyte_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               exc_any;
    logic [1:0]         cause_d;

    // Lower cause number wins when several exceptions arrive together.
    always_comb begin
        exc_any = exc_opcode | exc_overflow | exc_div0;
        cause_d = CAUSE_DIV0;
        if (exc_opcode) begin
            cause_d = CAUSE_OPCODE;
        end else if (exc_overflow) begin
            cause_d = CAUSE_OVF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cause_q <= 2'd0;
            epc_q   <= 32'd0;
            hbyte_q <= 8'd0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (exc_any) begin
                        cause_q <= cause_d;
                        state_q <= ST_CAPTURE;
                    end else if (rte_req) begin
                        state_q <= ST_RTE;
                    end
                end
                ST_CAPTURE: begin
                    epc_q   <= pc_q - 32'd4;
                    cnt_q   <= CNT_W'(MEM_LATENCY - 1);
                    state_q <= ST_VEC_WAIT;
                end
                ST_VEC_WAIT: begin
                    if (cnt_q == '0) begin
                        hbyte_q <= mem_rdata;
                        state_q <= ST_LOAD_PC;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_LOAD_PC: state_q <= ST_IDLE;
                ST_RTE:     state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Control-unit strobes only reach the PC mux while IDLE.
    always_comb begin
        pc_source    = ctrl_pc_source;
        pc_write     = ctrl_pc_write;
        busy         = 1'b0;
        handler_sel  = 1'b0;
        mem_addr_sel = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_CAPTURE, ST_VEC_WAIT: begin
                busy         = 1'b1;
                pc_source    = PCS_ALURES;
                pc_write     = 1'b0;
                mem_addr_sel = 1'b1;
            end
            ST_LOAD_PC: begin
                busy        = 1'b1;
                pc_source   = PCS_JUMP;
                pc_write    = 1'b1;
                handler_sel = 1'b1;
            end
            ST_RTE: begin
                busy      = 1'b1;
                pc_source = PCS_EPC;
                pc_write  = 1'b1;
            end
            default: begin
                busy      = 1'b1;
                pc_source = PCS_ALURES;
                pc_write  = 1'b0;
            end
        endcase
    end

    assign handler_addr = {24'd0, hbyte_q};
    assign exc_vec_addr = VEC_BASE + {30'd0, cause_q};
    assign epc          = epc_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_exception_pc_sequencer.sv
// Directed bench for exception_pc_sequencer: pass-through table plus hand-written
// exception, RTE, back-to-back and reset-abort sequences.
module tb_exception_pc_sequencer;
    import exception_pc_sequencer_pkg::*;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ctrl_pc_source;
    logic        ctrl_pc_write;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic        rte_req;
    logic [31:0] pc_q;
    logic [7:0]  mem_rdata;
    logic [1:0]  pc_source;
    logic        pc_write;
    logic        handler_sel;
    logic [31:0] handler_addr;
    logic        mem_addr_sel;
    logic [31:0] exc_vec_addr;
    logic [31:0] epc;
    logic        busy;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    exception_pc_sequencer #(.MEM_LATENCY(LAT), .VEC_BASE(32'd253)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_pc_source(ctrl_pc_source), .ctrl_pc_write(ctrl_pc_write),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
        .rte_req(rte_req), .pc_q(pc_q), .mem_rdata(mem_rdata),
        .pc_source(pc_source), .pc_write(pc_write), .handler_sel(handler_sel),
        .handler_addr(handler_addr), .mem_addr_sel(mem_addr_sel),
        .exc_vec_addr(exc_vec_addr), .epc(epc), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Driver / checker tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0; rte_req = 1'b0;
    endtask

    // Entered just after an edge with the DUT in IDLE; leaves it one cycle after LOAD_PC.
    task automatic run_exception(input logic op, input logic ovf, input logic dz, input logic rte,
                                 input logic [31:0] pc, input logic [7:0] rd,
                                 input logic [1:0] exp_cause, input string tag);
        exc_opcode = op; exc_overflow = ovf; exc_div0 = dz; rte_req = rte;
        pc_q = pc; mem_rdata = rd;
        ctrl_pc_source = PCS_ALUOUT; ctrl_pc_write = 1'b1;
        exp_q.push_back(pc - 32'd4);
        #1;
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        step();
        clear_reqs();
        check({tag, " capture state"}, 32'(dbg_state), 32'(ST_CAPTURE));
        check({tag, " capture busy"}, 32'(busy), 32'd1);
        check({tag, " capture pc_write"}, 32'(pc_write), 32'd0);
        check({tag, " capture mem_addr_sel"}, 32'(mem_addr_sel), 32'd1);
        check({tag, " vec addr"}, exc_vec_addr, 32'd253 + 32'(exp_cause));
        for (int i = 0; i < LAT; i++) begin
            step();
            check({tag, " wait state"}, 32'(dbg_state), 32'(ST_VEC_WAIT));
            check({tag, " wait mem_addr_sel"}, 32'(mem_addr_sel), 32'd1);
            check({tag, " wait pc_write"}, 32'(pc_write), 32'd0);
            if (i == 0) check({tag, " epc"}, epc, exp_q.pop_front());
        end
        step();
        check({tag, " load state"}, 32'(dbg_state), 32'(ST_LOAD_PC));
        check({tag, " load pc_source"}, 32'(pc_source), 32'(PCS_JUMP));
        check({tag, " load pc_write"}, 32'(pc_write), 32'd1);
        check({tag, " load handler_sel"}, 32'(handler_sel), 32'd1);
        check({tag, " handler_addr"}, handler_addr, {24'd0, rd});
        check({tag, " load busy"}, 32'(busy), 32'd1);
        ctrl_pc_write = 1'b0;
        step();
        check({tag, " back idle"}, 32'(dbg_state), 32'(ST_IDLE));
        check({tag, " idle pass src"}, 32'(pc_source), 32'(PCS_ALUOUT));
        check({tag, " idle pass wr"}, 32'(pc_write), 32'd0);
        check({tag, " idle busy0"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [1:0] src;
        logic       wr;
        logic [1:0] exp_src;
        logic       exp_wr;
    } pt_vec_t;

    pt_vec_t pt_tab[4];

    initial begin
        pt_tab[0] = '{2'b01, 1'b1, 2'b01, 1'b1};
        pt_tab[1] = '{2'b00, 1'b0, 2'b00, 1'b0};
        pt_tab[2] = '{2'b10, 1'b1, 2'b10, 1'b1};
        pt_tab[3] = '{2'b11, 1'b0, 2'b11, 1'b0};

        rst_n = 1'b0;
        clear_reqs();
        ctrl_pc_source = 2'b01; ctrl_pc_write = 1'b1;
        pc_q = 32'h0; mem_rdata = 8'h0;
        #12;
        check("reset pass src", 32'(pc_source), 32'd1);
        check("reset pass wr", 32'(pc_write), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset vec addr", exc_vec_addr, 32'd253);
        check("reset handler_addr", handler_addr, 32'd0);
        check("reset epc", epc, 32'd0);
        check("reset state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            ctrl_pc_source = pt_tab[i].src;
            ctrl_pc_write  = pt_tab[i].wr;
            #1;
            check($sformatf("pt%0d pc_source", i), 32'(pc_source), 32'(pt_tab[i].exp_src));
            check($sformatf("pt%0d pc_write", i), 32'(pc_write), 32'(pt_tab[i].exp_wr));
            check($sformatf("pt%0d busy", i), 32'(busy), 32'd0);
            check($sformatf("pt%0d handler_sel", i), 32'(handler_sel), 32'd0);
            check($sformatf("pt%0d mem_addr_sel", i), 32'(mem_addr_sel), 32'd0);
            step();
        end

        run_exception(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 8'h40, CAUSE_OVF, "ovf");
        run_exception(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 8'h80, CAUSE_OPCODE, "simul");
        check("simul no rte state", 32'(dbg_state), 32'(ST_IDLE));

        rte_req = 1'b1;
        ctrl_pc_source = PCS_ALURES; ctrl_pc_write = 1'b0;
        step();
        rte_req = 1'b0;
        check("rte state", 32'(dbg_state), 32'(ST_RTE));
        check("rte pc_source", 32'(pc_source), 32'(PCS_EPC));
        check("rte pc_write", 32'(pc_write), 32'd1);
        check("rte epc kept", epc, 32'h0000_00FC);
        check("rte busy", 32'(busy), 32'd1);
        step();
        check("rte back idle", 32'(dbg_state), 32'(ST_IDLE));

        run_exception(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 8'h5A, CAUSE_DIV0, "wrap");
        check("wrap epc", epc, 32'hFFFF_FFFC);

        exc_div0 = 1'b1; pc_q = 32'h200; mem_rdata = 8'h33;
        ctrl_pc_source = PCS_ALURES; ctrl_pc_write = 1'b0;
        step();
        clear_reqs();
        step();
        check("abort in wait", 32'(dbg_state), 32'(ST_VEC_WAIT));
        check("abort epc pre", epc, 32'h0000_01FC);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort busy", 32'(busy), 32'd0);
        check("abort epc", epc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort no pc_write", 32'(pc_write), 32'd0);
            check("abort held idle", 32'(dbg_state), 32'(ST_IDLE));
        end
        #2;
        rst_n = 1'b1;
        step();
        run_exception(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 8'h77, CAUSE_OVF, "rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
